// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: round-robin sharing of one up-counter between two requesters,
// each getting a cleared counter enabled for exactly its latched run length.
module counter_share_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             cnt_clr,
  output logic             cnt_en
);
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0]       state;
  logic [WIDTH-1:0] len_lat;
  logic             g, ptr, win, hit;
  // on a tie the requester not served last wins; ptr holds the last served index
  assign win = &req ? ~ptr : req[1];
  assign hit = cnt_q == len_lat;
  assign cnt_en = (state == RUN) && !hit;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      cnt_clr <= 1'b0;
      len_lat <= '0;
      g       <= 1'b0;
      ptr     <= 1'b1;
    end else begin
      done    <= '0;
      cnt_clr <= 1'b0;
      case (state)
        IDLE:
          if (|req) begin
            state   <= CLEAR;
            g       <= win;
            gnt     <= win ? 2'b10 : 2'b01;
            len_lat <= win ? len1 : len0;
            cnt_clr <= 1'b1;
          end
        CLEAR, RUN:
          if (!req[g]) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= g;
          end else if (state == CLEAR)
            state <= RUN;
          else if (hit) begin
            state <= DONE;
            done  <= g ? 2'b10 : 2'b01;
          end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          ptr   <= g;
        end
      endcase
    end
endmodule

// File: tb/tb_counter_share_arbiter.sv
// tb_counter_share_arbiter: directed plus random requests checked against a
// timeline model (grant start cycle, latched length, last-served pointer).
module tb_counter_share_arbiter;
  localparam int W = 2;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req = '0;
  logic [W-1:0] len0 = '0, len1 = '0, cnt_q = '0;
  logic [1:0]   gnt, done;
  logic         cnt_clr, cnt_en;
  int total = 0, bad = 0;
  int t = 0, s = 0, len = 0;
  bit busy = 1'b0, g = 1'b0, ptr = 1'b1;

  counter_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1), .cnt_q(cnt_q),
    .gnt(gnt), .done(done), .cnt_clr(cnt_clr), .cnt_en(cnt_en)
  );

  always #5 clk = ~clk;

  // the shared counter the arbiter controls
  always @(posedge clk)
    if (cnt_clr) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 1'b1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (model cycle %0d)", tag, got, exp, t);
    end
  endtask

  // a grant occupies cycles s..s+len+2: clear at s, counting s+1..s+len, done at s+len+2
  task automatic compare();
    int k;
    logic [1:0] oh;
    k = t - s;
    oh = g ? 2'b10 : 2'b01;
    chk("gnt", gnt, busy ? oh : 2'b00);
    chk("done", done, (busy && k == len + 2) ? oh : 2'b00);
    chk("cnt_clr", cnt_clr, busy && k == 0);
    chk("cnt_en", cnt_en, busy && k >= 1 && k <= len);
    if (busy && k == len + 1) chk("cnt_q_end", cnt_q, len);
    if (busy && k == len + 2) req[g] = 1'b0;
  endtask

  task automatic step();
    if (!busy) begin
      if (req != 2'b00) begin
        busy = 1'b1;
        s = t + 1;
        g = (req == 2'b11) ? (ptr == 1'b0) : (req == 2'b10);
        len = g ? int'(len1) : int'(len0);
      end
    end else if (t - s == len + 2 || !req[g]) begin
      busy = 1'b0;
      ptr = g;
    end
    @(posedge clk);
    #1;
    t++;
    compare();
  endtask

  initial begin
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_en", cnt_en, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare();
    // single request, len 3
    len0 = 2'd3;
    req = 2'b01;
    repeat (8) step();
    // tie straight after reset history: 0 served, then 1
    len0 = 2'd1;
    len1 = 2'd2;
    req = 2'b11;
    repeat (14) step();
    // zero length
    len1 = 2'd0;
    req = 2'b10;
    repeat (5) step();
    // abort after one enabled cycle
    len0 = 2'd3;
    req = 2'b01;
    step();
    step();
    req = 2'b00;
    repeat (3) step();
    chk("abort_cnt", cnt_q, 1);
    // maximum length with len changes mid-run
    len1 = 2'd3;
    req = 2'b10;
    repeat (3) step();
    len0 = 2'd1;
    repeat (6) step();
    len0 = 2'd3;
    req = 2'b01;
    repeat (3) step();
    len0 = 2'd0;
    repeat (6) step();
    // asynchronous reset mid-run
    len0 = 2'd3;
    req = 2'b01;
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_clr", cnt_clr, 0);
    chk("midrst_en", cnt_en, 0);
    busy = 1'b0;
    ptr = 1'b1;
    @(negedge clk);
    req = 2'b11;
    len0 = 2'd2;
    len1 = 2'd1;
    reset = 1'b0;
    step();
    chk("midrst_tie", gnt, 2'b01);
    repeat (12) step();
    // random traffic with withdrawals and length churn
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++)
        if (!req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end else if ($urandom_range(39) == 0) req[i] = 1'b0;
      if ($urandom_range(2) == 0) len0 = W'($urandom);
      if ($urandom_range(2) == 0) len1 = W'($urandom);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_share_arbiter.md
# counter_share_arbiter

Controller that shares a single WIDTH-bit up-counter between two requesters, each of which wants a timed run of a programmable number of counts. It arbitrates round-robin, clears the counter, enables it for exactly the requested count, and returns a one-cycle done pulse to the granted requester. It sits between the requester logic and the counter instance, and it owns the counter's clear and enable lines.

## Interface
- WIDTH, 2: counter width; also the width of the run lengths.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  request per requester; held high until done, or dropped to abort.
- len0  in  WIDTH  run length for requester 0, sampled at grant.
- len1  in  WIDTH  run length for requester 1, sampled at grant.
- cnt_q  in  WIDTH  current counter value, fed back from the counter.
- gnt  out  2  one-hot grant, high from CLEAR through DONE.
- done  out  2  one-cycle completion pulse to the granted requester.
- cnt_clr  out  1  synchronous clear to the counter; counter reads 0 on the next cycle.
- cnt_en  out  1  count enable; the counter increments by 1 per enabled cycle.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If any req bit is high, pick the winner, latch its len into len_lat, set gnt, and go to CLEAR.
- Arbitration:
  - If only one requester asserts req, it wins.
  - If both assert req, the one not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
- CLEAR:
  - Assert cnt_clr for one cycle, then go to RUN.
- RUN:
  - cnt_en = (state==RUN) && (cnt_q != len_lat). This is the only combinational output.
  - When cnt_q == len_lat, go to DONE.
  - The counter therefore sees exactly len_lat enabled cycles. len=0 gives zero enabled cycles.
- DONE:
  - done[g] = 1 for one cycle, gnt is still held, then go to IDLE.
  - The pointer updates to g.
- Abort:
  - If req[g] drops in CLEAR or RUN, the next state is IDLE.
  - gnt and cnt_en go low, and no done pulse is issued.
  - The pointer still updates to g.
- The non-granted requester's req is ignored until IDLE. It is never preempted.
- len changes after grant have no effect.
- All compares are unsigned WIDTH-bit. len = 2^WIDTH−1 is legal, and the counter never wraps during a run.

## Timing
- Reset values:
  - state = IDLE, gnt = 0, done = 0, cnt_clr = 0, cnt_en = 0, pointer = 1.
  - Reset takes effect immediately, including mid-run; cnt_en drops asynchronously.
- gnt, done and cnt_clr are registered. cnt_en is the combinational term above.
- Cycle-level sequence, with req first seen high in IDLE at cycle n:
  - cycle n+1: CLEAR (gnt and cnt_clr high).
  - cycles n+2 … n+2+len: RUN (cnt_en high for the first len of these cycles).
  - cycle n+3+len: DONE.
  - cycle n+4+len: IDLE.
- Request-to-done latency is len+3 cycles.
- Earliest next grant: CLEAR at n+5+len.
- Back-to-back service is therefore gated by one IDLE cycle.
- If req and reset deassert in the same cycle, reset dominates.

## Test plan
- Single request, WIDTH=2:
  - Stimulus: req=01, len0=3, req first high in IDLE at cycle 0.
  - Response: cnt_clr at 1; cnt_en at 2, 3, 4; cnt_en low at 5 with cnt_q=3; done=01 at 6; gnt=01 over cycles 1–6.
- Tie after reset:
  - Stimulus: req=11, len0=1, len1=2.
  - Response: requester 0 is served first (done=01). Requester 1 gets CLEAR two cycles after that done (done → IDLE → CLEAR), then done=10 after 2 enabled cycles. Neither is granted twice in a row.
- Zero length:
  - Stimulus: req=10, len1=0.
  - Response: cnt_en is never high; done=10 exactly 3 cycles after req is first seen.
- Abort:
  - Stimulus: req0 dropped after 1 enabled cycle of a len=3 run.
  - Response: cnt_en low and gnt=00 on the next cycle; no done pulse; cnt_q holds at 1.
- Reset mid-run:
  - Stimulus: assert reset during RUN.
  - Response: all outputs 0 immediately; after release, a req=11 tie grants requester 0 again.
- Maximum length:
  - Stimulus: WIDTH=2, len1=3, with a len0 change mid-run.
  - Response: exactly 3 enabled cycles; the mid-run len0 change has no effect.
